// File: rtl/battle_game_sequencer.sv
// rtl/battle_game_sequencer.sv - battleship game-flow FSM: decision, placement, alternating turns, win
// Optional turn timer enabled by defining TURN_TIMEOUT_EN.
module battle_game_sequencer #(
  parameter int MAX_SHIPS    = 5,
  parameter int CLK_HZ       = 50000000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ships_decided,
  input  logic [2:0] ship_amount,
  input  logic       player_place_done,
  input  logic       cpu_place_done,
  input  logic       player_fire,
  input  logic       player_hit,
  input  logic       cpu_fire,
  input  logic       cpu_hit,
  output logic       decision_State,
  output logic       colocation_ships_State,
  output logic       player_turn,
  output logic       cpu_turn,
  output logic       player_win,
  output logic       cpu_win,
  output logic [2:0] state_code,
  output logic [3:0] turn_secs_left
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECISION = 3'd1,
    PLACE_P  = 3'd2,
    PLACE_C  = 3'd3,
    P_TURN   = 3'd4,
    C_TURN   = 3'd5,
    P_WIN    = 3'd6,
    C_WIN    = 3'd7
  } state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_SHIPS);

  // Reject parameter values the counters and the 4-bit timer cannot represent.
  if (TURN_SECONDS < 1 || TURN_SECONDS > 15 || CLK_HZ < 1 || MAX_SHIPS < 1 || MAX_SHIPS > 7) begin : g_param_check
    $error("battle_game_sequencer: illegal parameter value");
  end

  state_t     state_q, state_d;
  logic [2:0] amount_q;
  logic [2:0] placed_p_q, placed_c_q, hits_p_q, hits_c_q;
  logic [2:0] placed_p_inc, placed_c_inc, hits_p_inc, hits_c_inc;
  logic       amount_ok;
  logic       timeout;

  // Counters saturate at MAX_SHIPS instead of wrapping.
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= MAX_CNT) ? v : v + 3'd1;
  endfunction

  assign placed_p_inc = sat_inc(placed_p_q);
  assign placed_c_inc = sat_inc(placed_c_q);
  assign hits_p_inc   = sat_inc(hits_p_q);
  assign hits_c_inc   = sat_inc(hits_c_q);
  assign amount_ok    = (ship_amount != 3'd0) && (ship_amount <= MAX_CNT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; only inputs owned by the current state are looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = DECISION;
      DECISION: if (ships_decided && amount_ok) state_d = PLACE_P;
      PLACE_P:  if (player_place_done && placed_p_inc == amount_q) state_d = PLACE_C;
      PLACE_C:  if (cpu_place_done && placed_c_inc == amount_q) state_d = P_TURN;
      P_TURN: begin
        if (player_fire) state_d = (player_hit && hits_p_inc == amount_q) ? P_WIN : C_TURN;
        else if (timeout) state_d = C_TURN;
      end
      C_TURN: begin
        if (cpu_fire) state_d = (cpu_hit && hits_c_inc == amount_q) ? C_WIN : P_TURN;
        else if (timeout) state_d = P_TURN;
      end
      P_WIN, C_WIN: if (start) state_d = DECISION;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode from the state register, so outputs move on the state-update edge.
  always_comb begin
    decision_State         = (state_q == DECISION);
    colocation_ships_State = (state_q == PLACE_P) || (state_q == PLACE_C);
    player_turn            = (state_q == P_TURN);
    cpu_turn               = (state_q == C_TURN);
    player_win             = (state_q == P_WIN);
    cpu_win                = (state_q == C_WIN);
    state_code             = state_q;
  end

  // Amount latch and placement/hit counters; counters clear on every entry to DECISION.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amount_q   <= 3'd0;
      placed_p_q <= 3'd0;
      placed_c_q <= 3'd0;
      hits_p_q   <= 3'd0;
      hits_c_q   <= 3'd0;
    end else begin
      if (state_q == DECISION && ships_decided && amount_ok) amount_q <= ship_amount;
      if (state_d == DECISION && state_q != DECISION) begin
        placed_p_q <= 3'd0;
        placed_c_q <= 3'd0;
        hits_p_q   <= 3'd0;
        hits_c_q   <= 3'd0;
      end else begin
        if (state_q == PLACE_P && player_place_done)         placed_p_q <= placed_p_inc;
        if (state_q == PLACE_C && cpu_place_done)            placed_c_q <= placed_c_inc;
        if (state_q == P_TURN && player_fire && player_hit)  hits_p_q   <= hits_p_inc;
        if (state_q == C_TURN && cpu_fire && cpu_hit)        hits_c_q   <= hits_c_inc;
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] presc_q;
  logic [3:0]    secs_q;
  logic          in_turn_q, in_turn_d, wrap;

  assign in_turn_q      = (state_q == P_TURN) || (state_q == C_TURN);
  assign in_turn_d      = (state_d == P_TURN) || (state_d == C_TURN);
  assign wrap           = in_turn_q && (presc_q == PW'(CLK_HZ - 1));
  assign timeout        = wrap && (secs_q == 4'd1);
  assign turn_secs_left = secs_q;

  // One-second prescaler and turn countdown; any change of turn (fire or expiry) reloads both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      secs_q  <= 4'd0;
    end else if (in_turn_d && state_d != state_q) begin
      presc_q <= '0;
      secs_q  <= 4'(TURN_SECONDS);
    end else if (in_turn_d) begin
      if (wrap) begin
        presc_q <= '0;
        secs_q  <= secs_q - 4'd1;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end else begin
      presc_q <= '0;
      secs_q  <= 4'd0;
    end
  end
`else
  assign timeout        = 1'b0;
  assign turn_secs_left = 4'd0;
`endif

endmodule

// File: tb/tb_battle_game_sequencer.sv
// tb/tb_battle_game_sequencer.sv - directed scoreboard bench for battle_game_sequencer
module tb_battle_game_sequencer;

  localparam int TS = 3;

  localparam logic [7:0] I_NONE = 8'h00;
  localparam logic [7:0] I_ST   = 8'h80;
  localparam logic [7:0] I_SD   = 8'h40;
  localparam logic [7:0] I_PPD  = 8'h20;
  localparam logic [7:0] I_CPD  = 8'h10;
  localparam logic [7:0] I_PF   = 8'h08;
  localparam logic [7:0] I_PH   = 8'h04;
  localparam logic [7:0] I_CF   = 8'h02;
  localparam logic [7:0] I_CH   = 8'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, ships_decided = 1'b0;
  logic [2:0] ship_amount = 3'd0;
  logic       player_place_done = 1'b0, cpu_place_done = 1'b0;
  logic       player_fire = 1'b0, player_hit = 1'b0, cpu_fire = 1'b0, cpu_hit = 1'b0;
  logic       decision_State, colocation_ships_State, player_turn, cpu_turn, player_win, cpu_win;
  logic [2:0] state_code;
  logic [3:0] turn_secs_left;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [12:0] v;
  } exp_t;
  exp_t sb_q[$];

  battle_game_sequencer #(.MAX_SHIPS(5), .CLK_HZ(4), .TURN_SECONDS(TS)) dut (
    .clk(clk), .rst(rst), .start(start), .ships_decided(ships_decided), .ship_amount(ship_amount),
    .player_place_done(player_place_done), .cpu_place_done(cpu_place_done),
    .player_fire(player_fire), .player_hit(player_hit), .cpu_fire(cpu_fire), .cpu_hit(cpu_hit),
    .decision_State(decision_State), .colocation_ships_State(colocation_ships_State),
    .player_turn(player_turn), .cpu_turn(cpu_turn), .player_win(player_win), .cpu_win(cpu_win),
    .state_code(state_code), .turn_secs_left(turn_secs_left)
  );

  always #5 clk = ~clk;

  // Expected output vector for a given state and remaining seconds.
  function automatic logic [12:0] exp_vec(input logic [2:0] st, input logic [3:0] secs);
    return {st == 3'd1, (st == 3'd2) || (st == 3'd3), st == 3'd4, st == 3'd5,
            st == 3'd6, st == 3'd7, st, secs};
  endfunction

  // Seconds shown right after entering / staying briefly in a state.
  function automatic logic [3:0] ts_of(input logic [2:0] st);
`ifdef TURN_TIMEOUT_EN
    return (st == 3'd4 || st == 3'd5) ? 4'(TS) : 4'd0;
`else
    return (st == 3'd4 || st == 3'd5) ? 4'd0 : 4'd0;
`endif
  endfunction

  task automatic push_exp(input string tag, input logic [2:0] st, input logic [3:0] secs);
    exp_t e;
    e.tag = tag;
    e.v   = exp_vec(st, secs);
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [12:0] obs;
    e   = sb_q.pop_front();
    obs = {decision_State, colocation_ships_State, player_turn, cpu_turn, player_win, cpu_win,
           state_code, turn_secs_left};
    checks++;
    assert (obs === e.v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  // Drive one cycle of input pulses, then compare outputs after the edge.
  task automatic cyc(input string tag, input logic [7:0] in, input logic [2:0] amt,
                     input logic [2:0] st, input logic [3:0] secs);
    {start, ships_decided, player_place_done, cpu_place_done,
     player_fire, player_hit, cpu_fire, cpu_hit} = in;
    ship_amount = amt;
    push_exp(tag, st, secs);
    @(posedge clk);
    #1;
    {start, ships_decided, player_place_done, cpu_place_done,
     player_fire, player_hit, cpu_fire, cpu_hit} = 8'h00;
    pop_check();
  endtask

  task automatic go(input string tag, input logic [7:0] in, input logic [2:0] amt, input logic [2:0] st);
    cyc(tag, in, amt, st, ts_of(st));
  endtask

  // Raise reset between edges and check outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    push_exp(tag, 3'd0, 4'd0);
    pop_check();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset_state", 3'd0, 4'd0);
    pop_check();
    rst = 1'b0;

    go("idle_ignores_decide", I_SD, 3'd2, 3'd0);
    go("idle_start",          I_ST, 3'd0, 3'd1);
    go("decide_zero",         I_SD, 3'd0, 3'd1);
    go("decide_six",          I_SD, 3'd6, 3'd1);
    go("decide_seven",        I_SD, 3'd7, 3'd1);
    go("decide_two",          I_SD, 3'd2, 3'd2);
    go("place_p_ign_cpu",     I_CPD, 3'd0, 3'd2);
    go("place_p_1",           I_PPD, 3'd0, 3'd2);
    go("place_p_2",           I_PPD, 3'd0, 3'd3);
    go("place_c_ign_amt",     I_PPD | I_SD, 3'd1, 3'd3);
    go("place_c_1",           I_CPD, 3'd0, 3'd3);
    go("place_c_2",           I_CPD, 3'd0, 3'd4);
    async_reset("reset_mid_game");

    go("g1_start",   I_ST, 3'd0, 3'd1);
    go("g1_decide",  I_SD, 3'd2, 3'd2);
    go("g1_pp1",     I_PPD, 3'd0, 3'd2);
    go("g1_pp2",     I_PPD, 3'd0, 3'd3);
    go("g1_cp1",     I_CPD, 3'd0, 3'd3);
    go("g1_cp2",     I_CPD, 3'd0, 3'd4);
    go("g1_p_hit",   I_PF | I_PH, 3'd0, 3'd5);
    go("g1_c_miss",  I_CF, 3'd0, 3'd4);
    go("g1_p_miss",  I_PF, 3'd0, 3'd5);
    go("g1_c_hit",   I_CF | I_CH, 3'd0, 3'd4);
    go("g1_ign_cpu", I_CF | I_CH, 3'd0, 3'd4);
    go("g1_p_win",   I_PF | I_PH, 3'd0, 3'd6);
    go("g1_win_hold", I_PF | I_PH, 3'd0, 3'd6);
    go("g1_restart", I_ST, 3'd0, 3'd1);

    go("g2_decide",  I_SD, 3'd2, 3'd2);
    go("g2_pp1",     I_PPD, 3'd0, 3'd2);
    go("g2_pp2",     I_PPD, 3'd0, 3'd3);
    go("g2_cp1",     I_CPD, 3'd0, 3'd3);
    go("g2_cp2",     I_CPD, 3'd0, 3'd4);
    go("g2_simul",   I_PF | I_PH | I_CF | I_CH, 3'd0, 3'd5);
    go("g2_c_hit",   I_CF | I_CH, 3'd0, 3'd4);
    go("g2_p_win",   I_PF | I_PH, 3'd0, 3'd6);
    go("g2_restart", I_ST, 3'd0, 3'd1);

    go("g3_decide5", I_SD, 3'd5, 3'd2);
    for (int i = 0; i < 4; i++) go("g3_pp_partial", I_PPD, 3'd0, 3'd2);
    go("g3_pp_last", I_PPD, 3'd0, 3'd3);
    for (int i = 0; i < 4; i++) go("g3_cp_partial", I_CPD, 3'd0, 3'd3);
    go("g3_cp_last", I_CPD, 3'd0, 3'd4);
`ifndef TURN_TIMEOUT_EN
    for (int k = 0; k < 13; k++) go("g3_no_timeout", I_NONE, 3'd0, 3'd4);
`endif
    async_reset("reset_again");

    go("g4_start",   I_ST, 3'd0, 3'd1);
    go("g4_decide1", I_SD, 3'd1, 3'd2);
    go("g4_pp",      I_PPD, 3'd0, 3'd3);
    go("g4_cp",      I_CPD, 3'd0, 3'd4);
`ifdef TURN_TIMEOUT_EN
    for (int k = 1; k < 12; k++) cyc("g4_p_countdown", I_NONE, 3'd0, 3'd4, 4'(TS - k / 4));
    cyc("g4_p_expire", I_NONE, 3'd0, 3'd5, 4'(TS));
    for (int k = 1; k < 12; k++) cyc("g4_c_countdown", I_NONE, 3'd0, 3'd5, 4'(TS - k / 4));
    cyc("g4_c_fire_on_expiry", I_CF | I_CH, 3'd0, 3'd7, 4'd0);
`else
    go("g4_p_miss",  I_PF, 3'd0, 3'd5);
    go("g4_c_win",   I_CF | I_CH, 3'd0, 3'd7);
`endif
    go("g4_restart", I_ST, 3'd0, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
